// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP and the
// fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection and fetch-address legality check.
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_take,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_legal
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);

  // Wraps modulo 2^32; running off the end is caught by the range check.
  assign pc_plus4 = pc + 32'd4;

  assign pc_legal = (pc[1:0] == 2'b00) && (pc <= LAST_PC);

  always_comb begin
    next_pc = pc;
    if (redirect_take) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/FAULT
// sequencing with a valid/ready stall from decode and branch redirects.
//
// state | meaning
// BOOT  | one cycle while instruction memory loads; no fetch
// RUN   | fetch one instruction per cycle unless stalled or redirected
// FAULT | illegal fetch address seen; frozen until rst
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_BYTES = 256
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instr,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [1:0]      fetch_state
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic            fire;
  logic            redirect_take;
  logic            advance;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            pc_legal;

  // IF/ID slot is free or being consumed this cycle.
  assign fire = !id_valid_q || id_ready;

  // Redirects steer the PC in BOOT and RUN; FAULT ignores them.
  assign redirect_take = redirect_valid && (state_q == BOOT || state_q == RUN);
  assign advance       = (state_q == RUN) && !redirect_valid && fire && pc_legal;

  fetch_pc_gen #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_gen (
    .pc            (pc_q),
    .redirect_take (redirect_take),
    .redirect_pc   (redirect_pc),
    .advance       (advance),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .pc_legal      (pc_legal)
  );

  always_comb begin
    state_d       = state_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          id_valid_d = 1'b0;
        end else if (fire) begin
          if (pc_legal) begin
            id_valid_d    = 1'b1;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_instr_d    = imem_instr;
          end else begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            id_valid_d = 1'b0;
          end
        end
      end
      FAULT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_instr_q    <= NOP;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= next_pc;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus queues the PCs
// expected to transfer; a negedge monitor checks each IF/ID handshake.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  fetch_state;

  int tests = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem [64];
  logic [31:0] held_instr;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (256)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_state    (fetch_state)
  );

  assign imem_instr = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_id_pc"}, id_pc, 32'h0);
    check({tag, "_id_pc4"}, id_pc_plus4, 32'h0);
    check({tag, "_id_instr"}, id_instr, 32'h0000_0013);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_fault_pc"}, fault_pc, 32'h0);
    check({tag, "_state"}, 32'(fetch_state), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL xfer_unexpected: got id_pc %h expected no transfer", id_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("xfer_pc", id_pc, e);
        check("xfer_pc4", id_pc_plus4, e + 32'd4);
        check("xfer_instr", id_instr, word_at(e));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | (32'(i) << 2);
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    check_reset("rst0");

    // Sequential fetch from reset.
    rst = 1'b0;
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    step();
    check("boot_state", 32'(fetch_state), 32'd1);
    check("boot_no_valid", 32'(id_valid), 32'd0);
    check("boot_addr", imem_addr, 32'h0);
    step();
    check("first_valid", 32'(id_valid), 32'd1);
    check("first_pc", id_pc, 32'h0);
    check("first_addr", imem_addr, 32'h4);
    step();
    check("seq_addr8", imem_addr, 32'h8);
    step();
    id_ready = 1'b0;
    held_instr = id_instr;
    check("stall_entry_pc", id_pc, 32'h8);

    // Stall three cycles.
    repeat (3) begin
      step();
      check("stall_pc", id_pc, 32'h8);
      check("stall_instr", id_instr, held_instr);
      check("stall_addr", imem_addr, 32'hC);
      check("stall_valid", 32'(id_valid), 32'd1);
    end
    id_ready = 1'b1;
    step();
    check("release_pc", id_pc, 32'hC);

    // Redirect while stalled.
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    step();
    check("redir_flush", 32'(id_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h14);
    redirect_valid = 1'b0;
    step();
    check("redir_valid", 32'(id_valid), 32'd1);
    check("redir_pc", id_pc, 32'h14);
    check("redir_instr", id_instr, word_at(32'h14));
    exp_q.push_back(32'h14);
    id_ready = 1'b1;
    step();

    // Misaligned redirect leads to fault.
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    step();
    check("mis_addr", imem_addr, 32'h22);
    check("mis_state_run", 32'(fetch_state), 32'd1);
    redirect_valid = 1'b0;
    step();
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_fault_pc", fault_pc, 32'h22);
    check("mis_state", 32'(fetch_state), 32'd2);
    check("mis_valid", 32'(id_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (2) step();
    check("fault_ignore_addr", imem_addr, 32'h22);
    check("fault_ignore_state", 32'(fetch_state), 32'd2);
    check("fault_ignore_valid", 32'(id_valid), 32'd0);
    check("fault_sticky", 32'(fault), 32'd1);
    redirect_valid = 1'b0;

    // Reset out of FAULT, then run off the end of memory.
    rst = 1'b1;
    step();
    check_reset("rst_fault");
    rst = 1'b0;
    id_ready = 1'b1;
    for (int a = 0; a < 256; a += 4) exp_q.push_back(32'(a));
    for (int i = 0; i < 200; i++) begin
      step();
      if (fault) break;
    end
    check("end_fault", 32'(fault), 32'd1);
    check("end_fault_pc", fault_pc, 32'h100);
    check("end_last_pc", id_pc, 32'hFC);
    check("end_state", 32'(fetch_state), 32'd2);
    check("end_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during a stall.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    id_ready = 1'b0;
    step();
    step();
    check("stall2_valid", 32'(id_valid), 32'd1);
    check("stall2_pc", id_pc, 32'h0);
    rst = 1'b1;
    step();
    check_reset("rst_stall");
    rst = 1'b0;
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    step();
    step();
    check("restart_pc", id_pc, 32'h0);
    step();
    step();
    id_ready = 1'b0;
    check("restart_pc8", id_pc, 32'h8);
    step();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
